// File: rtl/detector_pulse_gen_if.sv
// Bundle of the pulse generator's control inputs and sample/status outputs.
// The master side drives the controls and receives the sample stream.
// The slave side is the generator itself.
interface detector_pulse_gen_if;
    logic        en;
    logic        trig;
    logic [12:0] amp_in;
    logic [15:0] period_in;
    logic [13:0] outp;
    logic        pulse_start;
    logic        busy;
    logic [7:0]  count;

    modport master (
        output en, trig, amp_in, period_in,
        input  outp, pulse_start, busy, count
    );

    modport slave (
        input  en, trig, amp_in, period_in,
        output outp, pulse_start, busy, count
    );
endinterface

// File: rtl/detector_pulse_gen.sv
// Synthetic detector-pulse source feeding the trapezoidal shaper in place of
// the ADC. Each fire adds a programmable step to an internal level. The level
// then decays exponentially (level -= level>>TAU_SHIFT, at least 1 per cycle).
// A fire during a tail piles up on the remaining level, saturating at
// LEVEL_MAX. Fires come from trig or from a periodic interval counter.
// Optional build macro PULSE_NOISE_EN adds LFSR noise (-4..+3) to outp only.
module detector_pulse_gen #(
    parameter int                 TAU_SHIFT = 4,
    parameter logic signed [13:0] BASELINE  = 14'sd0,
    parameter logic [12:0]        LEVEL_MAX = 13'd8191
) (
    input  logic                clk,
    input  logic                rst,
    detector_pulse_gen_if.slave bus
);

    typedef enum logic {
        IDLE  = 1'b0,
        DECAY = 1'b1
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [12:0] level;
    logic [12:0] level_next;
    logic [12:0] decayed;
    logic [12:0] decay_step;
    logic [13:0] pile_sum;
    logic [15:0] interval;
    logic [15:0] interval_next;
    logic        periodic_hit;
    logic        fire;
    logic        pulse_start_q;
    logic [7:0]  count_q;
    logic signed [14:0] sum;
    logic [13:0] outp_sat;

`ifdef PULSE_NOISE_EN
    logic [15:0]        lfsr;
    logic signed [14:0] noise;

    // Free-running Fibonacci LFSR (taps 16,14,13,11) supplying output noise
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lfsr <= 16'hACE1;
        end else begin
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        end
    end
`endif

    // Fire request: external trigger, or the interval counter reaching its last count
    always_comb begin
        periodic_hit = bus.en && (bus.period_in != 16'd0) &&
                       (interval == bus.period_in - 16'd1);
        fire         = bus.trig || periodic_hit;
    end

    // One decay step; small levels drop by 1 so the tail always reaches 0
    always_comb begin
        decay_step = level >> TAU_SHIFT;
        decayed    = level;
        if (decay_step != 13'd0) begin
            decayed = level - decay_step;
        end else if (level != 13'd0) begin
            decayed = level - 13'd1;
        end else begin
            decayed = 13'd0;
        end
    end

    // Next level (pile-up add saturates), next interval count and next FSM state
    always_comb begin
        pile_sum      = {1'b0, decayed} + {1'b0, bus.amp_in};
        level_next    = decayed;
        interval_next = interval;
        state_next    = state;
        if (fire) begin
            if (pile_sum > {1'b0, LEVEL_MAX}) begin
                level_next = LEVEL_MAX;
            end else begin
                level_next = pile_sum[12:0];
            end
        end
        if (fire) begin
            interval_next = 16'd0;
        end else if ((bus.period_in != 16'd0) && (interval >= bus.period_in)) begin
            interval_next = 16'd0;
        end else if (bus.en && (bus.period_in != 16'd0)) begin
            interval_next = interval + 16'd1;
        end
        case (state)
            IDLE:    if (fire && (level_next != 13'd0)) state_next = DECAY;
            DECAY:   if (level_next == 13'd0) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // FSM state register: DECAY exactly while the registered level is nonzero
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Datapath registers: level, interval counter, start strobe, pulse count
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            level         <= 13'd0;
            interval      <= 16'd0;
            pulse_start_q <= 1'b0;
            count_q       <= 8'd0;
        end else begin
            level         <= level_next;
            interval      <= interval_next;
            pulse_start_q <= fire;
            count_q       <= count_q + {7'd0, fire};
        end
    end

    // Output sample: 15-bit signed sum of baseline and level, clipped to 14 bits.
    // Noise is forced to zero while reset is asserted so outp reads BASELINE.
    always_comb begin
`ifdef PULSE_NOISE_EN
        noise = rst ? {{12{lfsr[2]}}, lfsr[2:0]} : 15'sd0;
        sum   = {BASELINE[13], BASELINE} + $signed({2'b00, level}) + noise;
`else
        sum   = {BASELINE[13], BASELINE} + $signed({2'b00, level});
`endif
        if (sum > 15'sd8191) begin
            outp_sat = 14'h1FFF;
        end else if (sum < -15'sd8192) begin
            outp_sat = 14'h2000;
        end else begin
            outp_sat = sum[13:0];
        end
    end

    assign bus.outp        = outp_sat;
    assign bus.pulse_start = pulse_start_q;
    assign bus.busy        = (state == DECAY);
    assign bus.count       = count_q;

endmodule

// File: tb/tb_detector_pulse_gen.sv
// Self-checking bench for detector_pulse_gen (default build, no noise).
// Three instances share the same stimulus: BASELINE 0, -8000 and 8100.
module tb_detector_pulse_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en;
    logic        trig;
    logic [12:0] amp;
    logic [15:0] period;

    int          checks   = 0;
    int          failures = 0;
    logic [7:0]  exp_count = 8'd0;

    typedef struct {
        bit          drain;
        bit          trig;
        logic [12:0] amp;
        int          exp_outp;
        bit          exp_ps;
        bit          exp_busy;
    } vec_t;

    vec_t vecs[$];

    detector_pulse_gen_if bus0 ();
    detector_pulse_gen_if busn ();
    detector_pulse_gen_if busp ();

    assign bus0.en = en;  assign bus0.trig = trig;  assign bus0.amp_in = amp;  assign bus0.period_in = period;
    assign busn.en = en;  assign busn.trig = trig;  assign busn.amp_in = amp;  assign busn.period_in = period;
    assign busp.en = en;  assign busp.trig = trig;  assign busp.amp_in = amp;  assign busp.period_in = period;

    detector_pulse_gen #(.TAU_SHIFT(4), .BASELINE(14'sd0), .LEVEL_MAX(13'd8191)) dut (
        .clk(clk), .rst(rst), .bus(bus0)
    );
    detector_pulse_gen #(.TAU_SHIFT(4), .BASELINE(-14'sd8000), .LEVEL_MAX(13'd8191)) dut_neg (
        .clk(clk), .rst(rst), .bus(busn)
    );
    detector_pulse_gen #(.TAU_SHIFT(4), .BASELINE(14'sd8100), .LEVEL_MAX(13'd8191)) dut_pos (
        .clk(clk), .rst(rst), .bus(busp)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic applyStimulus(input bit t, input logic [12:0] a);
        trig = t;
        amp  = a;
    endtask

    task automatic checkOutput(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Let the shared level decay back to zero, bounded
    task automatic waitIdle();
        applyStimulus(1'b0, 13'd0);
        for (int i = 0; i < 1000 && bus0.busy; i++) tick();
        checkOutput("drain_idle", int'(bus0.busy), 0);
    endtask

    // Cycles until the next pulse_start, -1 on timeout
    task automatic measureGap(output int gap);
        bit found;
        found = 1'b0;
        gap   = 0;
        while (!found && gap < 300) begin
            tick();
            gap++;
            found = bus0.pulse_start;
        end
        if (!found) gap = -1;
    endtask

    initial begin
        int gap;
        int ps_seen;

        // Vectors: after driving the inputs, one rising edge, then compare
        vecs.push_back('{0, 1, 13'd1600, 1600, 1, 1});
        vecs.push_back('{0, 0, 13'd0,    1500, 0, 1});
        vecs.push_back('{0, 0, 13'd0,    1407, 0, 1});
        vecs.push_back('{0, 0, 13'd0,    1320, 0, 1});
        vecs.push_back('{1, 1, 13'd10,   10,   1, 1});
        for (int k = 1; k <= 10; k++) begin
            vecs.push_back('{0, 0, 13'd0, 10 - k, 0, (10 - k) != 0});
        end
        vecs.push_back('{0, 1, 13'd0,    0,    1, 0});
        vecs.push_back('{0, 0, 13'd0,    0,    0, 0});
        vecs.push_back('{1, 1, 13'd5000, 5000, 1, 1});
        vecs.push_back('{0, 1, 13'd5000, 8191, 1, 1});
        vecs.push_back('{0, 0, 13'd0,    7680, 0, 1});
        vecs.push_back('{0, 0, 13'd0,    7200, 0, 1});
        vecs.push_back('{1, 1, 13'd1600, 1600, 1, 1});
        vecs.push_back('{0, 1, 13'd100,  1600, 1, 1});
        vecs.push_back('{0, 0, 13'd0,    1500, 0, 1});

        en = 1'b0; trig = 1'b0; amp = 13'd0; period = 16'd0;

        // Reset state
        tick();
        checkOutput("reset_outp",   $signed(bus0.outp), 0);
        checkOutput("reset_outp_n", $signed(busn.outp), -8000);
        checkOutput("reset_outp_p", $signed(busp.outp), 8100);
        checkOutput("reset_busy",   int'(bus0.busy), 0);
        checkOutput("reset_ps",     int'(bus0.pulse_start), 0);
        checkOutput("reset_count",  int'(bus0.count), 0);
        #2 rst = 1'b1;
        tick();

        // Table-driven single-trigger, tail and pile-up vectors
        foreach (vecs[i]) begin
            if (vecs[i].drain) waitIdle();
            applyStimulus(vecs[i].trig, vecs[i].amp);
            tick();
            if (vecs[i].exp_ps) exp_count++;
            checkOutput($sformatf("vec%0d_outp", i),  $signed(bus0.outp), vecs[i].exp_outp);
            checkOutput($sformatf("vec%0d_ps", i),    int'(bus0.pulse_start), int'(vecs[i].exp_ps));
            checkOutput($sformatf("vec%0d_busy", i),  int'(bus0.busy), int'(vecs[i].exp_busy));
            checkOutput($sformatf("vec%0d_count", i), int'(bus0.count), int'(exp_count));
        end

        // Periodic firing every 100 cycles
        waitIdle();
        amp = 13'd50; en = 1'b1; period = 16'd100;
        measureGap(gap);
        exp_count++;
        checkOutput("period_gap1", gap, 100);
        checkOutput("period_count1", int'(bus0.count), int'(exp_count));
        measureGap(gap);
        exp_count++;
        checkOutput("period_gap2", gap, 100);
        checkOutput("period_count2", int'(bus0.count), int'(exp_count));

        // Period lowered below the running count: one clearing cycle, no fire,
        // then a full 50-cycle interval
        ps_seen = 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (bus0.pulse_start) ps_seen++;
        end
        checkOutput("period_no_early_fire", ps_seen, 0);
        period = 16'd50;
        measureGap(gap);
        exp_count++;
        checkOutput("period_change_gap", gap, 51);
        checkOutput("period_change_count", int'(bus0.count), int'(exp_count));

        // period_in=0 stops periodic firing
        period = 16'd0;
        ps_seen = 0;
        for (int i = 0; i < 250; i++) begin
            tick();
            if (bus0.pulse_start) ps_seen++;
        end
        checkOutput("period_zero_stops", ps_seen, 0);
        checkOutput("period_zero_count", int'(bus0.count), int'(exp_count));
        en = 1'b0;

        // Baseline offsets and output clipping
        waitIdle();
        applyStimulus(1'b1, 13'd100);
        tick();
        exp_count++;
        checkOutput("base0_amp100",    $signed(bus0.outp), 100);
        checkOutput("baseneg_amp100",  $signed(busn.outp), -7900);
        checkOutput("basepos_amp100",  $signed(busp.outp), 8191);
        waitIdle();
        applyStimulus(1'b1, 13'd500);
        tick();
        exp_count++;
        checkOutput("baseneg_amp500",  $signed(busn.outp), -7500);
        checkOutput("basepos_clip500", $signed(busp.outp), 8191);
        checkOutput("base_count",      int'(bus0.count), int'(exp_count));

        // Asynchronous reset in the middle of a tail
        waitIdle();
        applyStimulus(1'b1, 13'd3000);
        tick();
        exp_count++;
        checkOutput("tail_start", $signed(bus0.outp), 3000);
        applyStimulus(1'b0, 13'd0);
        tick(); tick(); tick();
        checkOutput("tail_busy", int'(bus0.busy), 1);
        #2 rst = 1'b0;
        #1;
        exp_count = 8'd0;
        checkOutput("async_rst_outp",   $signed(bus0.outp), 0);
        checkOutput("async_rst_outp_n", $signed(busn.outp), -8000);
        checkOutput("async_rst_busy",   int'(bus0.busy), 0);
        checkOutput("async_rst_count",  int'(bus0.count), 0);
        tick();
        #2 rst = 1'b1;
        tick();

        // Clean restart, then 256 fires total so count wraps to 0
        applyStimulus(1'b1, 13'd1600);
        tick();
        exp_count++;
        checkOutput("restart_outp",  $signed(bus0.outp), 1600);
        checkOutput("restart_ps",    int'(bus0.pulse_start), 1);
        checkOutput("restart_count", int'(bus0.count), int'(exp_count));
        for (int i = 0; i < 255; i++) begin
            applyStimulus(1'b1, 13'd0);
            tick();
            exp_count++;
            checkOutput($sformatf("wrap_ps%0d", i),    int'(bus0.pulse_start), 1);
            checkOutput($sformatf("wrap_count%0d", i), int'(bus0.count), int'(exp_count));
        end
        checkOutput("wrap_final_count", int'(bus0.count), 0);
        applyStimulus(1'b0, 13'd0);
        tick();
        checkOutput("wrap_no_strobe", int'(bus0.pulse_start), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/detector_pulse_gen.md
Name: detector_pulse_gen

Overview:
- Synthetic detector-pulse source for the trapezoidal shaping chain. It generates 14-bit two's-complement samples that look like a preamplifier/ADC stream: an instantaneous step of programmable amplitude, then an exponential decay.
- It drives the shaper's 14-bit sample input in place of the ADC, for bench and in-system self-test.
- Pulses fire periodically or on an external trigger. A pulse arriving during a tail piles up on the remaining level.

Parameters:
- TAU_SHIFT, 4, decay shift; per-cycle decrement is level>>TAU_SHIFT, giving time constant ≈ 2^TAU_SHIFT cycles.
- BASELINE, 0, signed 14-bit constant added to every output sample.
- LEVEL_MAX, 8191, saturation ceiling for the internal level (13-bit positive).

Ports:
- clk  input  1  sample clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-low reset.
- en  input  1  enables periodic firing. Trigger and decay are unaffected.
- trig  input  1  single-cycle external fire request.
- amp_in  input  13  step amplitude, unsigned; sampled in the fire cycle.
- period_in  input  16  periodic interval in cycles; 0 disables periodic firing.
- outp  output  14  two's-complement sample = sat14(BASELINE + level [+ noise]).
- pulse_start  output  1  one-cycle strobe, aligned with the first outp sample of each pulse.
- busy  output  1  high while level != 0.
- count  output  8  number of pulses fired, modulo 256.

Behaviour:
- Reset (rst=0, asynchronous):
  - level=0, interval counter=0, state IDLE, count=0, pulse_start=0, busy=0.
  - outp=sat14(BASELINE); no noise is applied during reset.
- States:
  - IDLE (level=0). Fire → DECAY.
  - DECAY (level>0). Level reaches 0 with no fire → IDLE. Fire → stay in DECAY.
- Fire condition in cycle N: trig=1, or (en=1 and period_in!=0 and interval counter == period_in-1).
  - Trig and periodic firing in the same cycle give a single fire.
- Interval counter:
  - Increments each cycle while en=1 and period_in!=0; clears to 0 on any fire.
  - Holds while en=0.
  - If period_in changes to a value ≤ the current count, the counter clears without firing.
- Level update, registered:
  - Fire: level <= min(decayed(level) + amp_in, LEVEL_MAX). This is the pile-up path; the add saturates.
  - Otherwise: level <= decayed(level).
  - decayed(L) = L - (L>>TAU_SHIFT) if (L>>TAU_SHIFT) != 0; L-1 if 0 < L < 2^TAU_SHIFT; 0 if L=0. The tail always reaches 0.
- Latency: a fire in cycle N shows on outp and pulse_start in cycle N+1. busy follows the registered level.
- Fire with amp_in=0:
  - pulse_start still strobes and count still increments.
  - The level follows decay only.
- count: increments on each fire and wraps 255→0.
- Output arithmetic:
  - 15-bit signed sum of BASELINE and level, clipped to [-8192, 8191].
  - No wrap-around is permitted.

Optional Feature:
- Macro PULSE_NOISE_EN.
- Defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1 on reset) advances every cycle.
  - Its low 3 bits, sign-extended (-4..+3), are added into the outp sum before saturation.
  - Level, busy, pulse_start and count are unaffected.
- Undefined: no LFSR logic is present; outp = sat14(BASELINE + level) exactly.

Test Plan:
- TAU_SHIFT=4, BASELINE=0. Trig pulse with amp_in=1600 → next cycle outp=1600 and pulse_start=1, then 1500, then 1407, then 1320; busy=1 throughout.
- Fire with amp_in=10 → outp 10,9,8,…,1,0 on consecutive cycles; busy drops in the cycle outp reaches 0; state returns to IDLE.
- en=1, period_in=100, trig=0 → pulse_start exactly every 100 cycles; count increments 0→1→2; period_in=0 stops firing.
- Pile-up: amp_in=5000 fired two cycles in a row → second level = min(5000-312+5000, 8191) = 8191; outp=8191, not wrapped.
- BASELINE=-8000, amp_in=100 → outp=-7900; with BASELINE=8100, amp_in=500 → outp clips to 8191.
- Assert rst=0 mid-decay (level≈3000) → outp=BASELINE immediately, without waiting for clk; busy=0, count=0. After release, the next trig restarts cleanly. 256 fires → count wraps to 0.
